// File: rtl/bo_datapath.sv
// Operative block (datapath) for the BC control FSM: operand X, accumulator S, result Hr, shared ALU.
// Define BO_SATURATE_EN to clamp overflowing results instead of wrapping modulo 2**WIDTH.
module bo_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             LX,
  input  logic             LS,
  input  logic             LH,
  input  logic             H,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  output logic [WIDTH-1:0] X_out,
  output logic [WIDTH-1:0] S_out,
  output logic [WIDTH-1:0] H_out,
  output logic             zero,
  output logic             ovf,
  output logic             h_valid,
  output logic [CNT_W-1:0] h_count
);

  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   r_h;
  logic               r_ovf;
  logic               r_hValid;
  logic [CNT_W-1:0]   r_hCount;

  logic [WIDTH-1:0]   w_opA;
  logic [WIDTH-1:0]   w_opB;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_aluOvf;
  logic               w_setOvf;

  always_comb begin
    w_opA = r_x;
    case (M0)
      2'd0: w_opA = r_x;
      2'd1: w_opA = r_s;
      2'd2: w_opA = r_h;
      2'd3: w_opA = {{(WIDTH-1){1'b0}}, 1'b1};
      default: w_opA = r_x;
    endcase
  end

  always_comb begin
    w_opB = r_x;
    case (M1)
      2'd0: w_opB = r_x;
      2'd1: w_opB = r_s;
      2'd2: w_opB = r_h;
      2'd3: w_opB = '0;
      default: w_opB = r_x;
    endcase
  end

  assign w_sum  = {1'b0, w_opA} + {1'b0, w_opB};
  assign w_prod = {{WIDTH{1'b0}}, w_opA} * {{WIDTH{1'b0}}, w_opB};

  // Overflow means the exact result does not fit in WIDTH unsigned bits.
  always_comb begin
    w_res    = w_opA;
    w_aluOvf = 1'b0;
    case (M2)
      2'd0: begin
        w_res    = w_sum[WIDTH-1:0];
        w_aluOvf = w_sum[WIDTH];
`ifdef BO_SATURATE_EN
        if (w_sum[WIDTH]) w_res = '1;
`endif
      end
      2'd1: begin
        w_res    = w_opA - w_opB;
        w_aluOvf = (w_opA < w_opB);
`ifdef BO_SATURATE_EN
        if (w_opA < w_opB) w_res = '0;
`endif
      end
      2'd2: begin
        w_res    = w_prod[WIDTH-1:0];
        w_aluOvf = |w_prod[2*WIDTH-1:WIDTH];
`ifdef BO_SATURATE_EN
        if (|w_prod[2*WIDTH-1:WIDTH]) w_res = '1;
`endif
      end
      2'd3: begin
        w_res    = w_opA;
        w_aluOvf = 1'b0;
      end
      default: begin
        w_res    = w_opA;
        w_aluOvf = 1'b0;
      end
    endcase
  end

  assign w_setOvf = w_aluOvf & (LS | (LH & H));

  // All loads share one edge and see pre-edge register values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_s      <= '0;
      r_h      <= '0;
      r_ovf    <= 1'b0;
      r_hValid <= 1'b0;
      r_hCount <= '0;
    end else begin
      if (LX) r_x <= x_in;
      if (LS) r_s <= w_res;
      if (LH) begin
        r_h      <= H ? w_res : r_s;
        r_hCount <= r_hCount + 1'b1;
      end
      r_hValid <= LH;
      // A new overflow on the same edge as LX wins over the clear.
      if (w_setOvf)  r_ovf <= 1'b1;
      else if (LX)   r_ovf <= 1'b0;
    end
  end

  assign X_out   = r_x;
  assign S_out   = r_s;
  assign H_out   = r_h;
  assign zero    = (r_s == '0);
  assign ovf     = r_ovf;
  assign h_valid = r_hValid;
  assign h_count = r_hCount;

endmodule

// File: tb/tb_bo_datapath.sv
// Scoreboard bench for bo_datapath: directed steps push hand-computed register states,
// a monitor pops and compares after every clock edge or asynchronous reset.
module tb_bo_datapath;

`ifdef BO_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x_in;
  logic       LX, LS, LH, H;
  logic [1:0] M0, M1, M2;
  logic [7:0] X_out, S_out, H_out, h_count;
  logic       zero, ovf, h_valid;

  typedef struct {
    string      name;
    logic [7:0] x;
    logic [7:0] s;
    logic [7:0] h;
    logic       ovf;
    logic       hv;
    logic [7:0] hc;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  bo_datapath #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .x_in(x_in),
    .LX(LX), .LS(LS), .LH(LH), .H(H),
    .M0(M0), .M1(M1), .M2(M2),
    .X_out(X_out), .S_out(S_out), .H_out(H_out),
    .zero(zero), .ovf(ovf), .h_valid(h_valid), .h_count(h_count)
  );

  always #5 clk = ~clk;

  // Compare the whole visible state against one popped expectation.
  task automatic checkOutput(input exp_t e);
    logic ez;
    ez = (e.s == 8'd0);
    testsRun++;
    if (X_out !== e.x || S_out !== e.s || H_out !== e.h || zero !== ez ||
        ovf !== e.ovf || h_valid !== e.hv || h_count !== e.hc) begin
      testsFailed++;
      $display("[TB] FAIL %s: got X=%0d S=%0d H=%0d zero=%0b ovf=%0b hv=%0b hc=%0d, want X=%0d S=%0d H=%0d zero=%0b ovf=%0b hv=%0b hc=%0d",
               e.name, X_out, S_out, H_out, zero, ovf, h_valid, h_count,
               e.x, e.s, e.h, ez, e.ovf, e.hv, e.hc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic pushExp(input string name, input logic [7:0] ex, es, eh,
                         input logic eovf, ehv, input logic [7:0] ehc);
    exp_t e;
    e.name = name; e.x = ex; e.s = es; e.h = eh;
    e.ovf = eovf; e.hv = ehv; e.hc = ehc;
    expQ.push_back(e);
  endtask

  // Called at a falling edge: drive one control word and queue the state after the next rise.
  task automatic applyStimulus(input string name,
                               input logic lx, ls, lh, hs,
                               input logic [1:0] m0, m1, m2,
                               input logic [7:0] xin,
                               input logic [7:0] ex, es, eh,
                               input logic eovf, ehv, input logic [7:0] ehc);
    LX = lx; LS = ls; LH = lh; H = hs;
    M0 = m0; M1 = m1; M2 = m2; x_in = xin;
    pushExp(name, ex, es, eh, eovf, ehv, ehc);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    LX = 0; LS = 0; LH = 0; H = 0; M0 = 0; M1 = 0; M2 = 0; x_in = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("reset_state", 0,0,0,0, 0,0,0, 8'd0,   0,   0, 0, 0,0,0);
    applyStimulus("load_x5",     1,0,0,0, 0,0,0, 8'd5,   5,   0, 0, 0,0,0);
    applyStimulus("add_x_x",     0,1,0,0, 0,0,0, 8'd0,   5,  10, 0, 0,0,0);
    applyStimulus("lh_sub_s_x",  0,0,1,1, 1,0,1, 8'd0,   5,  10, 5, 0,1,1);
    applyStimulus("hv_drops",    0,0,0,0, 0,0,0, 8'd0,   5,  10, 5, 0,0,1);
    applyStimulus("lh_from_s",   0,0,1,0, 0,0,0, 8'd0,   5,  10,10, 0,1,2);
    applyStimulus("lh_pass_hr",  0,0,1,1, 2,0,3, 8'd0,   5,  10,10, 0,1,3);
    applyStimulus("idle_hold",   0,0,0,0, 0,0,0, 8'd0,   5,  10,10, 0,0,3);

    applyStimulus("load_x20",    1,0,0,0, 0,0,0, 8'd20, 20,  10,10, 0,0,3);
    applyStimulus("mul_ovf",     0,1,0,0, 0,0,2, 8'd0,  20, SAT ? 8'd255 : 8'd144, 10, 1,0,3);
    applyStimulus("lx_clr_ovf",  1,0,0,0, 0,0,0, 8'd3,   3, SAT ? 8'd255 : 8'd144, 10, 0,0,3);
    applyStimulus("sub_to_zero", 0,1,0,0, 0,0,1, 8'd0,   3,   0,10, 0,0,3);
    applyStimulus("sub_borrow",  0,1,0,0, 1,0,1, 8'd0,   3, SAT ? 8'd0 : 8'd253, 10, 1,0,3);
    applyStimulus("lx_x4",       1,0,0,0, 0,0,0, 8'd4,   4, SAT ? 8'd0 : 8'd253, 10, 0,0,3);
    applyStimulus("lx_ls_same",  1,1,0,0, 0,3,0, 8'd9,   9,   4,10, 0,0,3);
    applyStimulus("lh_s_no_ovf", 0,0,1,0, 1,0,1, 8'd0,   9,   4, 4, 0,1,4);
    applyStimulus("lh_alu_ovf",  0,0,1,1, 1,0,1, 8'd0,   9,   4, SAT ? 8'd0 : 8'd251, 1,1,5);
    applyStimulus("set_wins_lx", 1,1,0,0, 3,0,1, 8'd200, 200, SAT ? 8'd0 : 8'd248, SAT ? 8'd0 : 8'd251, 1,0,5);
    applyStimulus("lx_clr2",     1,0,0,0, 0,0,0, 8'd200, 200, SAT ? 8'd0 : 8'd248, SAT ? 8'd0 : 8'd251, 0,0,5);
    applyStimulus("add_carry",   0,1,0,0, 0,0,0, 8'd0, 200, SAT ? 8'd255 : 8'd144, SAT ? 8'd0 : 8'd251, 1,0,5);

    // Asynchronous reset between clock edges, then held through an edge with LX active.
    #2;
    pushExp("async_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus("reset_hold",  1,1,1,1, 0,0,0, 8'd77,  0,   0, 0, 0,0,0);
    reset = 1'b0;

    for (int i = 1; i <= 255; i++)
      applyStimulus("hcount_up", 0,0,1,0, 0,0,0, 8'd0, 0, 0, 0, 0,1, 8'(i));
    applyStimulus("hcount_wrap", 0,0,1,0, 0,0,0, 8'd0,   0,   0, 0, 0,1,0);
    applyStimulus("wrap_idle",   0,0,0,0, 0,0,0, 8'd0,   0,   0, 0, 0,0,0);

    for (int t = 0; t < 20 && expQ.size() > 0; t++) @(negedge clk);
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
